dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the single-cycle MIPS datapath and an external burst port (loader/DMA/debug). CPU loads and stores pass through combinationally, so the single-cycle timing is preserved. External word bursts are sequenced by an address/beat counter FSM and interleaved with CPU accesses. When the CPU loses arbitration, `cpu_stall` is asserted, which freezes the PC register and gates `regwrite` for that cycle.

## Interface
- `LENW`, default 8: width of the burst-length field. The maximum burst is 2^LENW−1 words.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low. 0 = reset, sampled on `clk`.
- `cpu_memread` in 1: the datapath requests a load this cycle.
- `cpu_memwrite` in 1: the datapath requests a store this cycle.
- `cpu_addr` in 32: byte address (datapath `aluout`).
- `cpu_wdata` in 32: store data (datapath `writedata`).
- `cpu_be` in 4: byte enables for the CPU access.
- `cpu_rdata` out 32: load data returned to the datapath (`readdata`).
- `cpu_stall` out 1: the CPU request was not granted this cycle. The datapath holds its PC and suppresses the register write.
- `ext_start` in 1: one-cycle pulse that starts a burst. Ignored while `ext_busy`=1.
- `ext_we` in 1: burst direction, captured at start. 1 = write, 0 = read.
- `ext_addr` in 32: burst start address, captured at start. Bits [1:0] are forced to 0.
- `ext_len` in LENW: number of words in the burst, captured at start.
- `ext_wdata` in 32: write-beat data.
- `ext_wvalid` in 1: write-beat data is valid.
- `ext_wready` out 1: write beat accepted this cycle.
- `ext_rdata` out 32: read-beat data.
- `ext_rvalid` out 1: read-beat data is valid.
- `ext_busy` out 1: a burst is in progress.
- `ext_done` out 1: one-cycle pulse at burst completion.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; dmem reads are combinational.

## Operation
- **FSM states.** IDLE, BURST, DONE.
  - IDLE → BURST on `ext_start` when `ext_len`≠0.
  - IDLE → DONE on `ext_start` when `ext_len`=0. No memory access is made.
  - BURST → DONE in the cycle after the last beat is granted.
  - DONE → IDLE unconditionally after one cycle. `ext_done`=1 while in DONE.
- **Burst registers.** On start, capture `addr_q` = {`ext_addr`[31:2], 2'b00}, `left_q` = `ext_len`, and `we_q` = `ext_we`.
  - On each granted beat: `addr_q` += 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000), and `left_q` −= 1.
- **Request signals.**
  - CPU request: `cpu_req` = `cpu_memread` | `cpu_memwrite`.
  - External request: `ext_req` = (state==BURST) & (`we_q` ? `ext_wvalid` : 1).
- **Arbitration** (combinational):
  - If only one side requests, that side is granted.
  - On a conflict, the winner is selected by the `last_q` pointer (see Configuration).
  - `last_q` updates to the side granted, on every cycle that has a grant.
- **Memory mux.**
  - CPU granted: `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_be`=`cpu_be`, `mem_we`=`cpu_memwrite`.
  - Ext granted: `mem_addr`=`addr_q`, `mem_wdata`=`ext_wdata`, `mem_be`=4'b1111, `mem_we`=`we_q`.
  - No grant: `mem_we`=0.
- `cpu_rdata` = `mem_rdata` at all times.
- `cpu_stall` = `cpu_req` & ~`cpu_gnt`.
- `ext_wready` = `ext_gnt` & `we_q`.
- Read beat granted: `ext_rdata` ← `mem_rdata` and `ext_rvalid` ← 1 on the next edge; otherwise `ext_rvalid` ← 0. `ext_rdata` holds its value between beats.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State → IDLE, `left_q`=0, `addr_q`=0, `last_q`=EXT (the CPU wins the first conflict).
  - `ext_rvalid`=0, `ext_rdata`=0, `ext_done`=0, `ext_busy`=0.
  - While `reset`=0, `mem_we`=0, `ext_wready`=0 and `cpu_stall`=0.
  - A reset mid-burst aborts the burst with no `ext_done`. Beats already written remain in memory.
- **CPU path.** Zero latency; address, write enable and read data are combinational in the same cycle.
- **Write beat.** Completes in the cycle where `ext_wvalid`=1 and `ext_wready`=1.
- **Read beat.** Data is valid 1 cycle after the grant.
- **Burst length.**
  - An N-beat burst with no CPU traffic occupies N cycles in BURST, then 1 cycle in DONE.
  - `ext_busy`=1 in BURST and DONE.
- **Back-to-back starts.** `ext_start` asserted in the same cycle as DONE is ignored; the next start is accepted in IDLE.
- **Stalled CPU.** Holds its request unchanged; it is guaranteed a grant on the next cycle when round-robin is enabled.

## Configuration
- **`DMEM_ARB_RR_EN` defined.** Round-robin on conflict: the side not equal to `last_q` wins. Worst-case CPU stall is 1 cycle per conflict.
- **`DMEM_ARB_RR_EN` undefined.** The CPU always wins conflicts; `last_q` is still maintained but ignored. The ext port progresses only on cycles with no CPU memory access. `cpu_stall` is constantly 0 except under reset.

## Test plan
- **Reset hold.** `reset`=0 for 3 cycles with `cpu_memwrite`=1 and `ext_start`=1 → `mem_we`=0, `cpu_stall`=0, `ext_busy`=0, `ext_rvalid`=0.
- **CPU-only store then load.** Store 0xDEADBEEF to 0x40 with `cpu_be`=1111, then load from 0x40 → `mem_we`=1 in the store cycle; `cpu_rdata`=0xDEADBEEF in the load cycle; `cpu_stall`=0 throughout.
- **Ext write burst.** Burst of 4 words at 0x103 (aligned to 0x100), `ext_wvalid`=1 with data 1..4 → writes to 0x100..0x10C on 4 consecutive cycles; `ext_done` pulses in cycle 5; `ext_busy` falls in cycle 6.
- **Conflict with `DMEM_ARB_RR_EN` defined.** Read burst of 3 words with `cpu_memread`=1 every cycle → grants alternate CPU, EXT, CPU, EXT, …; `cpu_stall`=1 on the EXT cycles; `ext_rvalid` asserts the cycle after each EXT grant.
- **Fixed priority, wrap, zero length** (`DMEM_ARB_RR_EN` undefined):
  - Burst of 2 words at 0xFFFFFFFC → addresses 0xFFFFFFFC then 0x00000000; `cpu_stall` never asserts.
  - Burst with `ext_len`=0 → `ext_done` 1 cycle after start, no `mem_we`.
- **Reset mid-burst.** Assert `reset`=0 after 2 of 5 beats → no `ext_done`; state is IDLE; a new start is accepted on the first cycle after reset is released.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the single-cycle CPU and an external burst port.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise the CPU always wins.
module dmem_arbiter #(
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_memread,
  input  logic            cpu_memwrite,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  input  logic [3:0]      cpu_be,
  output logic [31:0]     cpu_rdata,
  output logic            cpu_stall,
  input  logic            ext_start,
  input  logic            ext_we,
  input  logic [31:0]     ext_addr,
  input  logic [LENW-1:0] ext_len,
  input  logic [31:0]     ext_wdata,
  input  logic            ext_wvalid,
  output logic            ext_wready,
  output logic [31:0]     ext_rdata,
  output logic            ext_rvalid,
  output logic            ext_busy,
  output logic            ext_done,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q;
  logic [LENW-1:0] left_q;
  logic            we_q;
  logic            last_q;
  logic            cpu_req, ext_req, cpu_gnt, ext_gnt, cpu_wins;

  // last_q is 1 when the external port held the most recent grant
  always_comb begin
    cpu_req = reset & (cpu_memread | cpu_memwrite);
    ext_req = reset & (state_q == BURST) & (we_q ? ext_wvalid : 1'b1);
`ifdef DMEM_ARB_RR_EN
    cpu_wins = last_q;
`else
    cpu_wins = 1'b1;
`endif
    cpu_gnt = cpu_req & (~ext_req | cpu_wins);
    ext_gnt = ext_req & ~cpu_gnt;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ext_start) state_d = (ext_len == '0) ? DONE : BURST;
      BURST:   if (ext_gnt && left_q == LENW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_be    = cpu_be;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_we = cpu_memwrite;
    end else if (ext_gnt) begin
      mem_addr  = addr_q;
      mem_wdata = ext_wdata;
      mem_be    = 4'hF;
      mem_we    = we_q;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign ext_wready = ext_gnt & we_q;
  assign ext_busy   = (state_q != IDLE);
  assign ext_done   = (state_q == DONE);

  // Reset mid-burst simply drops the burst; no done pulse is produced
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b1;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= (cpu_gnt | ext_gnt) ? ext_gnt : last_q;
      ext_rvalid <= ext_gnt & ~we_q;
      if (ext_gnt & ~we_q) ext_rdata <= mem_rdata;
      if (state_q == IDLE && ext_start) begin
        addr_q <= ext_addr & 32'hFFFF_FFFC;
        left_q <= ext_len;
        we_q   <= ext_we;
      end else if (ext_gnt) begin
        addr_q <= addr_q + 32'd4;
        left_q <= left_q - LENW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic compared against a queue-based reference model.
module tb_dmem_arbiter;
  localparam int LENW = 8;
  localparam logic H = 1'b1, L = 1'b0;

  logic            clk, reset;
  logic            cpu_memread, cpu_memwrite;
  logic [31:0]     cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]      cpu_be;
  logic            cpu_stall;
  logic            ext_start, ext_we, ext_wvalid, ext_wready, ext_rvalid, ext_busy, ext_done;
  logic [31:0]     ext_addr, ext_wdata, ext_rdata;
  logic [LENW-1:0] ext_len;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256] = '{default: '0};
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic rst, rd, wr; logic [31:0] caddr, cwdata; logic [3:0] be;
    logic st, we; logic [31:0] eaddr; logic [LENW-1:0] len; logic [31:0] ewdata; logic wv;
    logic x_we, x_stall, x_busy, x_done, x_wready, x_rvalid;
    logic ca; logic [31:0] xaddr; logic cr; logic [31:0] xrd; logic ce; logic [31:0] xerd;
  } vec_t;

  dmem_arbiter #(.LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_start(ext_start), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_wvalid(ext_wvalid), .ext_wready(ext_wready),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_busy(ext_busy), .ext_done(ext_done),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational-read data memory with byte-enabled writes
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model: pending beat addresses in a queue, plus done/read-return flags
  int unsigned mq[$];
  bit          m_done = 1'b0, m_we = 1'b0, m_last_ext = 1'b1, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] ref_mem [256] = '{default: '0};

  function automatic void model_eval(output bit cr, output bit cg, output bit eg);
    bit er;
    cr = (reset === 1'b1) && (cpu_memread || cpu_memwrite);
    er = (reset === 1'b1) && (mq.size() != 0) && (!m_we || ext_wvalid);
    if (cr && er) begin
`ifdef DMEM_ARB_RR_EN
      cg = m_last_ext;
`else
      cg = 1'b1;
`endif
      eg = !cg;
    end else begin
      cg = cr;
      eg = er;
    end
  endfunction

  task automatic model_step();
    bit cr, cg, eg, was_idle, done_next;
    logic [31:0] a, base;
    model_eval(cr, cg, eg);
    if (reset !== 1'b1) begin
      mq.delete();
      m_done = 1'b0; m_last_ext = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      was_idle  = (mq.size() == 0) && !m_done;
      done_next = 1'b0;
      m_rvalid  = 1'b0;
      if (cg) begin
        m_last_ext = 1'b0;
        if (cpu_memwrite)
          for (int b = 0; b < 4; b++)
            if (cpu_be[b]) ref_mem[cpu_addr[9:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
      end
      if (eg) begin
        m_last_ext = 1'b1;
        a = mq.pop_front();
        if (m_we) ref_mem[a[9:2]] = ext_wdata;
        else begin
          m_rvalid = 1'b1;
          m_rdata  = ref_mem[a[9:2]];
        end
        if (mq.size() == 0) done_next = 1'b1;
      end
      if (was_idle && ext_start) begin
        m_we = ext_we;
        base = ext_addr & 32'hFFFF_FFFC;
        if (ext_len == 0) done_next = 1'b1;
        for (int i = 0; i < int'(ext_len); i++) mq.push_back(base + 32'(4 * i));
      end
      m_done = done_next;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h, expected %h", tag, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; cpu_memread = v.rd; cpu_memwrite = v.wr; cpu_addr = v.caddr;
    cpu_wdata = v.cwdata; cpu_be = v.be; ext_start = v.st; ext_we = v.we;
    ext_addr = v.eaddr; ext_len = v.len; ext_wdata = v.ewdata; ext_wvalid = v.wv;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check(tag, "mem_we", 32'(mem_we), 32'(v.x_we));
    check(tag, "cpu_stall", 32'(cpu_stall), 32'(v.x_stall));
    check(tag, "ext_busy", 32'(ext_busy), 32'(v.x_busy));
    check(tag, "ext_done", 32'(ext_done), 32'(v.x_done));
    check(tag, "ext_wready", 32'(ext_wready), 32'(v.x_wready));
    check(tag, "ext_rvalid", 32'(ext_rvalid), 32'(v.x_rvalid));
    if (v.ca) check(tag, "mem_addr", mem_addr, v.xaddr);
    if (v.cr) check(tag, "cpu_rdata", cpu_rdata, v.xrd);
    if (v.ce) check(tag, "ext_rdata", ext_rdata, v.xerd);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput(v, tag);
  endtask

  function automatic vec_t base();
    vec_t v;
    v = '{default: '0};
    v.rst = H;
    return v;
  endfunction

  task automatic checkModel(input int cyc);
    bit cr, cg, eg;
    logic [31:0] a;
    string tag;
    tag = $sformatf("rand%0d", cyc);
    model_eval(cr, cg, eg);
    check(tag, "mem_we", 32'(mem_we), 32'(cg ? cpu_memwrite : (eg ? m_we : 1'b0)));
    check(tag, "cpu_stall", 32'(cpu_stall), 32'(cr && !cg));
    check(tag, "ext_wready", 32'(ext_wready), 32'(eg && m_we));
    check(tag, "ext_busy", 32'(ext_busy), 32'((mq.size() != 0) || m_done));
    check(tag, "ext_done", 32'(ext_done), 32'(m_done));
    check(tag, "ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid));
    check(tag, "ext_rdata", ext_rdata, m_rdata);
    if (cg) begin
      check(tag, "mem_addr", mem_addr, cpu_addr);
      check(tag, "cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
      if (cpu_memwrite) check(tag, "mem_be", 32'(mem_be), 32'(cpu_be));
    end else if (eg) begin
      a = mq[0];
      check(tag, "mem_addr", mem_addr, a);
      check(tag, "cpu_rdata", cpu_rdata, ref_mem[a[9:2]]);
      if (m_we) begin
        check(tag, "mem_wdata", mem_wdata, ext_wdata);
        check(tag, "mem_be", 32'(mem_be), 32'hF);
      end
    end
  endtask

  initial begin
    vec_t tbl [13];
    vec_t v;
    reset = L; cpu_memread = L; cpu_memwrite = L; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    ext_start = L; ext_we = L; ext_addr = '0; ext_len = '0; ext_wdata = '0; ext_wvalid = L;

    // rst rd wr caddr cwdata be | st we eaddr len ewdata wv | we stall busy done wready rvalid | ca addr | cr rdata | ce erdata
    tbl[0]  = '{L,L,H,32'h40,32'h0,4'hF, H,H,32'h100,LENW'(3),32'h0,H, L,L,L,L,L,L, L,32'h0,   L,32'h0,        L,32'h0};
    tbl[1]  = '{L,L,H,32'h40,32'h0,4'hF, H,H,32'h100,LENW'(3),32'h0,H, L,L,L,L,L,L, L,32'h0,   L,32'h0,        L,32'h0};
    tbl[2]  = '{L,L,H,32'h40,32'h0,4'hF, H,H,32'h100,LENW'(3),32'h0,H, L,L,L,L,L,L, L,32'h0,   L,32'h0,        L,32'h0};
    tbl[3]  = '{H,L,H,32'h40,32'hDEADBEEF,4'hF, L,L,32'h0,LENW'(0),32'h0,L, H,L,L,L,L,L, H,32'h40, L,32'h0,    L,32'h0};
    tbl[4]  = '{H,H,L,32'h40,32'h0,4'hF, L,L,32'h0,LENW'(0),32'h0,L, L,L,L,L,L,L, H,32'h40,  H,32'hDEADBEEF, L,32'h0};
    tbl[5]  = '{H,L,L,32'h0,32'h0,4'h0, H,H,32'h103,LENW'(4),32'h0,L, L,L,L,L,L,L, L,32'h0,   L,32'h0,        L,32'h0};
    tbl[6]  = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h1,H, H,L,H,L,H,L, H,32'h100,  L,32'h0,        L,32'h0};
    tbl[7]  = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h2,H, H,L,H,L,H,L, H,32'h104,  L,32'h0,        L,32'h0};
    tbl[8]  = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h3,H, H,L,H,L,H,L, H,32'h108,  L,32'h0,        L,32'h0};
    tbl[9]  = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h4,H, H,L,H,L,H,L, H,32'h10C,  L,32'h0,        L,32'h0};
    tbl[10] = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h0,L, L,L,H,H,L,L, L,32'h0,    L,32'h0,        L,32'h0};
    tbl[11] = '{H,L,L,32'h0,32'h0,4'h0, L,L,32'h0,LENW'(0),32'h0,L, L,L,L,L,L,L, L,32'h0,    L,32'h0,        L,32'h0};
    tbl[12] = '{H,H,L,32'h108,32'h0,4'hF, L,L,32'h0,LENW'(0),32'h0,L, L,L,L,L,L,L, H,32'h108, H,32'h3,        L,32'h0};

    for (int i = 0; i < 13; i++) runVec(tbl[i], $sformatf("tbl%0d", i));

    // Read burst of 3 against a CPU loading every cycle
    v = base(); v.rst = L; runVec(v, "confRst");
    v = base(); v.st = H; v.eaddr = 32'h100; v.len = LENW'(3); runVec(v, "confStart");
`ifdef DMEM_ARB_RR_EN
    for (int k = 1; k <= 7; k++) begin
      v = base(); v.rd = H; v.caddr = 32'h40; v.x_busy = H; v.ca = H; v.cr = H;
      if (k % 2 == 1) begin
        v.xaddr = 32'h40; v.xrd = 32'hDEADBEEF;
      end else begin
        v.x_stall = H; v.xaddr = 32'h100 + 32'(4 * (k / 2 - 1)); v.xrd = 32'(k / 2);
      end
      if (k >= 3 && k % 2 == 1) begin v.x_rvalid = H; v.ce = H; v.xerd = 32'((k - 1) / 2); end
      if (k == 7) v.x_done = H;
      runVec(v, $sformatf("confRR%0d", k));
    end
`else
    for (int k = 1; k <= 7; k++) begin
      v = base(); v.x_busy = H; v.ca = H; v.cr = H;
      if (k <= 3) begin
        v.rd = H; v.caddr = 32'h40; v.xaddr = 32'h40; v.xrd = 32'hDEADBEEF;
      end else if (k <= 6) begin
        v.xaddr = 32'h100 + 32'(4 * (k - 4)); v.xrd = 32'(k - 3);
      end else begin
        v.ca = L; v.cr = L; v.x_done = H;
      end
      if (k >= 5) begin v.x_rvalid = H; v.ce = H; v.xerd = 32'(k - 4); end
      runVec(v, $sformatf("confFix%0d", k));
    end
`endif
    v = base(); runVec(v, "confEnd");

    // Address wrap at the top of memory, then a zero-length burst
    v = base(); v.st = H; v.we = H; v.eaddr = 32'hFFFF_FFFE; v.len = LENW'(2); v.wv = H; runVec(v, "wrap0");
    v = base(); v.wv = H; v.ewdata = 32'hA5A5_0001; v.x_we = H; v.x_wready = H; v.x_busy = H; v.ca = H; v.xaddr = 32'hFFFF_FFFC; runVec(v, "wrap1");
    v = base(); v.wv = H; v.ewdata = 32'hA5A5_0002; v.x_we = H; v.x_wready = H; v.x_busy = H; v.ca = H; v.xaddr = 32'h0; runVec(v, "wrap2");
    v = base(); v.x_busy = H; v.x_done = H; runVec(v, "wrap3");
    v = base(); runVec(v, "wrap4");
    v = base(); v.st = H; v.we = H; v.len = LENW'(0); runVec(v, "zero0");
    v = base(); v.wv = H; v.x_busy = H; v.x_done = H; runVec(v, "zero1");
    v = base(); runVec(v, "zero2");
    v = base(); v.rd = H; v.caddr = 32'hFFFF_FFFC; v.cr = H; v.xrd = 32'hA5A5_0001; runVec(v, "wrapRd0");
    v = base(); v.rd = H; v.caddr = 32'h0; v.cr = H; v.xrd = 32'hA5A5_0002; runVec(v, "wrapRd1");

    // Reset after two of five write beats, then an immediate new read burst
    v = base(); v.st = H; v.we = H; v.eaddr = 32'h200; v.len = LENW'(5); runVec(v, "mid0");
    v = base(); v.wv = H; v.ewdata = 32'h11; v.x_we = H; v.x_wready = H; v.x_busy = H; v.ca = H; v.xaddr = 32'h200; runVec(v, "mid1");
    v = base(); v.wv = H; v.ewdata = 32'h22; v.x_we = H; v.x_wready = H; v.x_busy = H; v.ca = H; v.xaddr = 32'h204; runVec(v, "mid2");
    v = base(); v.rst = L; v.wv = H; v.rd = H; v.x_busy = H; runVec(v, "mid3");
    v = base(); v.st = H; v.eaddr = 32'h200; v.len = LENW'(1); runVec(v, "mid4");
    v = base(); v.x_busy = H; v.ca = H; v.xaddr = 32'h200; v.cr = H; v.xrd = 32'h11; runVec(v, "mid5");
    v = base(); v.x_busy = H; v.x_done = H; v.x_rvalid = H; v.ce = H; v.xerd = 32'h11; runVec(v, "mid6");
    v = base(); v.ce = H; v.xerd = 32'h11; runVec(v, "mid7");

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset        = ($urandom_range(99) != 0);
      cpu_memread  = ($urandom_range(2) == 0);
      cpu_memwrite = ($urandom_range(3) == 0);
      cpu_addr     = $urandom;
      cpu_wdata    = $urandom;
      cpu_be       = 4'($urandom);
      ext_start    = ($urandom_range(5) == 0);
      ext_we       = ($urandom_range(1) == 1);
      ext_addr     = $urandom;
      ext_len      = LENW'($urandom_range(6));
      ext_wdata    = $urandom;
      ext_wvalid   = ($urandom_range(1) == 1);
      #2;
      checkModel(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
